// File: rtl/hex_ascii_streamer.sv
// Renders a DATA_W-bit word as uppercase/lowercase hex ASCII, most significant nibble first.
// Define HEX_ASCII_STREAMER_CRLF_EN to append CR LF to every frame.
module hex_ascii_streamer #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_lower,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_char,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam int NIB = DATA_W / 4;
  localparam logic [CNT_W-1:0] TOP_IDX = CNT_W'(NIB - 1);
`ifdef HEX_ASCII_STREAMER_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

`ifdef HEX_ASCII_STREAMER_CRLF_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, TERM_CR = 2'd2, TERM_LF = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1} state_t;
`endif

  state_t            state;
  logic [DATA_W-1:0] data_q;
  logic              lower_q;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  idx_dec;
  logic              xfer;

  // 0x37 / 0x57 are 'A'-10 and 'a'-10
  function automatic logic [7:0] to_ascii(input logic [3:0] nib, input logic lower);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return (lower ? 8'h57 : 8'h37) + {4'h0, nib};
  endfunction

  function automatic logic [3:0] nib_at(input logic [DATA_W-1:0] w, input logic [CNT_W-1:0] i);
    return w[int'(i)*4 +: 4];
  endfunction

  assign xfer    = out_valid & out_ready;
  assign idx_dec = idx - CNT_W'(1);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      data_q    <= '0;
      lower_q   <= 1'b0;
      idx       <= '0;
      in_ready  <= 1'b0;
      out_char  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready is registered so it rises one edge after reset release
          in_ready <= 1'b1;
          if (in_ready && in_valid) begin
            data_q    <= in_data;
            lower_q   <= in_lower;
            idx       <= TOP_IDX;
            out_char  <= to_ascii(in_data[DATA_W-1 -: 4], in_lower);
            out_valid <= 1'b1;
            out_last  <= (NIB == 1) && !CRLF;
            in_ready  <= 1'b0;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (xfer) begin
            if (idx == '0) begin
`ifdef HEX_ASCII_STREAMER_CRLF_EN
              out_char <= 8'h0D;
              out_last <= 1'b0;
              state    <= TERM_CR;
`else
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              state     <= IDLE;
`endif
            end else begin
              idx      <= idx_dec;
              out_char <= to_ascii(nib_at(data_q, idx_dec), lower_q);
              out_last <= (idx_dec == '0) && !CRLF;
            end
          end
        end
`ifdef HEX_ASCII_STREAMER_CRLF_EN
        TERM_CR: begin
          if (xfer) begin
            out_char <= 8'h0A;
            out_last <= 1'b1;
            state    <= TERM_LF;
          end
        end
        TERM_LF: begin
          if (xfer) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
`endif
        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_ascii_streamer.sv
// Directed bench for hex_ascii_streamer with 8-, 16- and 128-bit instances.
module tb_hex_ascii_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_lower, out_ready;
  logic [7:0]   a_data;  logic a_iv, a_ir, a_ov, a_ol, a_busy; logic [7:0] a_oc;
  logic [15:0]  b_data;  logic b_iv, b_ir, b_ov, b_ol, b_busy; logic [7:0] b_oc;
  logic [127:0] c_data;  logic c_iv, c_ir, c_ov, c_ol, c_busy; logic [7:0] c_oc;

`ifdef HEX_ASCII_STREAMER_CRLF_EN
  localparam string TERM = "\r\n";
`else
  localparam string TERM = "";
`endif

  hex_ascii_streamer #(.DATA_W(8), .CNT_W(1)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_lower(in_lower), .in_valid(a_iv),
    .in_ready(a_ir), .out_char(a_oc), .out_valid(a_ov), .out_ready(out_ready),
    .out_last(a_ol), .busy(a_busy));

  hex_ascii_streamer #(.DATA_W(16), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_lower(in_lower), .in_valid(b_iv),
    .in_ready(b_ir), .out_char(b_oc), .out_valid(b_ov), .out_ready(out_ready),
    .out_last(b_ol), .busy(b_busy));

  hex_ascii_streamer #(.DATA_W(128), .CNT_W(5)) dut_c (
    .clk(clk), .rst(rst), .in_data(c_data), .in_lower(in_lower), .in_valid(c_iv),
    .in_ready(c_ir), .out_char(c_oc), .out_valid(c_ov), .out_ready(out_ready),
    .out_last(c_ol), .busy(c_busy));

  int checks = 0;
  int errors = 0;
  int sel = 0;
  logic cur_ir, cur_ov, cur_ol, cur_busy;
  logic [7:0] cur_oc;

  always_comb begin
    cur_ir = a_ir; cur_ov = a_ov; cur_ol = a_ol; cur_busy = a_busy; cur_oc = a_oc;
    case (sel)
      1: begin cur_ir = b_ir; cur_ov = b_ov; cur_ol = b_ol; cur_busy = b_busy; cur_oc = b_oc; end
      2: begin cur_ir = c_ir; cur_ov = c_ov; cur_ol = c_ol; cur_busy = c_busy; cur_oc = c_oc; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic [127:0] d, input logic v);
    case (s)
      0: begin a_data = d[7:0];  a_iv = v; end
      1: begin b_data = d[15:0]; b_iv = v; end
      default: begin c_data = d; c_iv = v; end
    endcase
  endtask

  // Called one time-unit after a rising edge with the selected instance idle.
  task automatic run_frame(input int s, input logic [127:0] d, input logic lo,
                           input bit bp, input bit hold, input string exp);
    int k = 0;
    int n = exp.len();
    logic [7:0] pc = 8'h00;
    logic pl = 1'b0;
    bit stalled = 1'b0;
    bit done = 1'b0;
    sel = s;
    in_lower = lo;
    drive(s, d, 1'b1);
    out_ready = 1'b1;
    chk("idle_ready", {7'd0, cur_ir}, 8'd1);
    step();
    chk("accept_valid", {7'd0, cur_ov}, 8'd1);
    chk("accept_busy", {7'd0, cur_busy}, 8'd1);
    // Disturb the inputs mid-frame; the latched word must not change.
    if (hold) in_lower = ~lo;
    else begin drive(s, ~d, 1'b0); in_lower = ~lo; end
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      if (stalled) begin
        chk("stall_char", cur_oc, pc);
        chk("stall_last", {7'd0, cur_ol}, {7'd0, pl});
      end
      if (hold) chk("busy_not_ready", {7'd0, cur_ir}, 8'd0);
      chk("frame_valid", {7'd0, cur_ov}, 8'd1);
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = !out_ready;
      pc = cur_oc;
      pl = cur_ol;
      if (out_ready) begin
        chk($sformatf("char%0d", k), cur_oc, exp[k]);
        chk($sformatf("last%0d", k), {7'd0, cur_ol}, {7'd0, (k == n - 1)});
        k++;
        if (k == n) done = 1'b1;
      end
      step();
    end
    chk("frame_len", 8'(k), 8'(n));
    chk("end_ready", {7'd0, cur_ir}, 8'd1);
    chk("end_valid", {7'd0, cur_ov}, 8'd0);
    chk("end_busy", {7'd0, cur_busy}, 8'd0);
    drive(s, '0, 1'b0);
    out_ready = 1'b1;
    step();
    chk("no_reaccept", {7'd0, cur_ov}, 8'd0);
  endtask

  initial begin
    rst = 1'b1; in_lower = 1'b0; out_ready = 1'b0;
    a_data = '0; b_data = '0; c_data = '0;
    a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0;
    #1;
    chk("rst_ready", {7'd0, a_ir}, 8'd0);
    chk("rst_valid", {7'd0, a_ov}, 8'd0);
    chk("rst_char", a_oc, 8'h00);
    chk("rst_last", {7'd0, a_ol}, 8'd0);
    chk("rst_busy", {7'd0, a_busy}, 8'd0);
    step(); step();
    rst = 1'b0;
    chk("rel_ready_before_edge", {7'd0, a_ir}, 8'd0);
    step();
    chk("rel_ready_after_edge", {7'd0, a_ir}, 8'd1);
    chk("rel_ready_after_edge_c", {7'd0, c_ir}, 8'd1);

    run_frame(0, 128'hA5, 1'b0, 1'b0, 1'b0, {"A5", TERM});
    run_frame(0, 128'hFE, 1'b1, 1'b0, 1'b0, {"fe", TERM});
    run_frame(0, 128'h09, 1'b1, 1'b1, 1'b0, {"09", TERM});
    run_frame(2, 128'h00112233445566778899AABBCCDDEEFF, 1'b0, 1'b0, 1'b0,
              {"00112233445566778899AABBCCDDEEFF", TERM});
    run_frame(2, 128'h0123456789ABCDEFFEDCBA9876543210, 1'b1, 1'b1, 1'b1,
              {"0123456789abcdeffedcba9876543210", TERM});

    // Reset after two characters of a 16-bit frame.
    sel = 1;
    in_lower = 1'b0;
    out_ready = 1'b1;
    drive(1, 128'hBEEF, 1'b1);
    step();
    drive(1, '0, 1'b0);
    chk("pre_rst_char0", b_oc, 8'h42);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("midrst_valid", {7'd0, b_ov}, 8'd0);
    chk("midrst_last", {7'd0, b_ol}, 8'd0);
    chk("midrst_char", b_oc, 8'h00);
    chk("midrst_busy", {7'd0, b_busy}, 8'd0);
    chk("midrst_ready", {7'd0, b_ir}, 8'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_ready", {7'd0, b_ir}, 8'd1);
    chk("post_rst_quiet", {7'd0, b_ov}, 8'd0);
    step();
    chk("post_rst_quiet2", {7'd0, b_ov}, 8'd0);
    run_frame(1, 128'h1234, 1'b0, 1'b0, 1'b0, {"1234", TERM});
    step();
    chk("post_frame_quiet", {7'd0, b_ov}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
